// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S microphone receiver.
package i2s_pkg;

    localparam int SLOT_BITS     = 32;
    localparam int SAMPLE_BITS   = 24;
    localparam int FRAME_SLOTS   = 2;
    localparam int BIT_CNT_BITS  = $clog2(SLOT_BITS * FRAME_SLOTS);
    localparam int SLOT_IDX_BITS = $clog2(SLOT_BITS);
    // Wide enough for the largest legal stretch (64*2*255-1).
    localparam int STRETCH_BITS  = 16;

    // Channel encodings; the value equals the WS level of that slot.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    // Data bits sit in slots 1..SAMPLE_BITS (one-bit I2S delay after WS changes).
    function automatic logic is_data_slot(input logic [SLOT_IDX_BITS-1:0] slot);
        return (slot >= SLOT_IDX_BITS'(1)) && (slot <= SLOT_IDX_BITS'(SAMPLE_BITS));
    endfunction

endpackage

// File: rtl/i2s_mic_rx_if.sv
// Microphone-side bus: serial data in, bit clock / word select out, plus the
// parallel sample and its stretched valid level.
interface i2s_mic_rx_if;
    import i2s_pkg::*;

    logic                   SD;
    logic                   SCK;
    logic                   WS;
    logic [SAMPLE_BITS-1:0] o_SAMPLE;
    logic                   SAMPLE_VALID;

    // Receiver side: drives the I2S clocks and the sample outputs.
    modport master (
        input  SD,
        output SCK,
        output WS,
        output o_SAMPLE,
        output SAMPLE_VALID
    );

    // Microphone / consumer side.
    modport slave (
        output SD,
        input  SCK,
        input  WS,
        input  o_SAMPLE,
        input  SAMPLE_VALID
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock and word-select generator. SCK toggles every CLK_DIV clk
// cycles; bit_cnt advances on every SCK fall and WS is its MSB, so WS can only
// change together with an SCK fall. The rise/fall strobes are high for the one
// clk cycle right after SCK changed level.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    output logic                    o_sck,
    output logic                    o_ws,
    output logic                    o_sck_rise,
    output logic                    o_sck_fall,
    output logic [BIT_CNT_BITS-1:0] o_bit_cnt
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]              r_div;
    logic                    r_sck;
    logic                    r_sck_rise;
    logic                    r_sck_fall;
    logic [BIT_CNT_BITS-1:0] r_bit_cnt;
    logic                    w_wrap;

    assign w_wrap = (r_div == DIV_LAST);

    // Divider, SCK toggle, edge strobes and slot counter.
    // NOTE: every register here uses <= so all of them see the same pre-edge
    // values; a blocking update would let later statements see the new SCK.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_div      <= '0;
            r_sck      <= 1'b0;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            if (w_wrap) begin
                r_div      <= '0;
                r_sck      <= ~r_sck;
                r_sck_rise <= ~r_sck;
                r_sck_fall <= r_sck;
                if (r_sck) begin
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_BITS'(1);
                end
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    assign o_sck      = r_sck;
    assign o_ws       = r_bit_cnt[BIT_CNT_BITS-1];
    assign o_sck_rise = r_sck_rise;
    assign o_sck_fall = r_sck_fall;
    assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: generates SCK/WS, synchronizes SD, shifts in the
// selected channel's 24 data bits MSB-first and presents each completed word
// with a SAMPLE_VALID level that stays high for VALID_STRETCH clk cycles.
// The first frame after reset is dropped because its clocks start mid-stream
// for the microphone.
module i2s_mic_rx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int VALID_STRETCH = 8,
    parameter int CHANNEL       = 0
) (
    input  logic         clk,
    input  logic         RESET,
    i2s_mic_rx_if.master bus
);

    if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("i2s_mic_rx: CLK_DIV must be within 4..255");
    end
    if (VALID_STRETCH < 1 || VALID_STRETCH > 64 * 2 * CLK_DIV - 1) begin : g_bad_stretch
        $error("i2s_mic_rx: VALID_STRETCH must be within 1..(128*CLK_DIV-1)");
    end
    if (CHANNEL != int'(CH_LEFT) && CHANNEL != int'(CH_RIGHT)) begin : g_bad_channel
        $error("i2s_mic_rx: CHANNEL must be 0 (left) or 1 (right)");
    end

    localparam logic                     CH_WS          = (CHANNEL == int'(CH_RIGHT));
    localparam logic [STRETCH_BITS-1:0]  STRETCH_LAST   = STRETCH_BITS'(VALID_STRETCH - 1);
    localparam logic [SLOT_IDX_BITS-1:0] LAST_DATA_SLOT = SLOT_IDX_BITS'(SAMPLE_BITS);

    logic                     w_sck;
    logic                     w_ws;
    logic                     w_sck_rise;
    logic                     w_sck_fall;
    logic [BIT_CNT_BITS-1:0]  w_bit_cnt;
    logic [SLOT_IDX_BITS-1:0] w_slot;
    logic                     w_capture;
    logic                     w_word_done;
    logic [SAMPLE_BITS-1:0]   w_next_word;

    logic                     r_sd_meta;
    logic                     r_sd_sync;
    logic [SAMPLE_BITS-1:0]   r_shift;
    logic [SAMPLE_BITS-1:0]   r_sample;
    logic                     r_valid;
    logic [STRETCH_BITS-1:0]  r_stretch_cnt;
    logic                     r_first_frame;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .RESET      (RESET),
        .o_sck      (w_sck),
        .o_ws       (w_ws),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_bit_cnt  (w_bit_cnt)
    );

    assign w_slot      = w_bit_cnt[SLOT_IDX_BITS-1:0];
    assign w_capture   = w_sck_rise && (w_ws == CH_WS) && is_data_slot(w_slot);
    assign w_word_done = w_capture && (w_slot == LAST_DATA_SLOT);
    assign w_next_word = {r_shift[SAMPLE_BITS-2:0], r_sd_sync};

    // Two-flop synchronizer for the asynchronous SD line.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_sd_meta <= 1'b0;
            r_sd_sync <= 1'b0;
        end else begin
            r_sd_meta <= bus.SD;
            r_sd_sync <= r_sd_meta;
        end
    end

    // Shift the synchronized SD in on each data-slot SCK rise of our channel.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_shift <= '0;
        end else if (w_capture) begin
            r_shift <= w_next_word;
        end
    end

    // Hold off output until the slot counter has completed one full frame.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_first_frame <= 1'b1;
        end else if (w_sck_fall && (w_bit_cnt == '0)) begin
            r_first_frame <= 1'b0;
        end
    end

    // Load the completed word and run the SAMPLE_VALID stretch counter.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_sample      <= '0;
            r_valid       <= 1'b0;
            r_stretch_cnt <= '0;
        end else if (w_word_done && !r_first_frame) begin
            r_sample      <= w_next_word;
            r_valid       <= 1'b1;
            r_stretch_cnt <= STRETCH_LAST;
        end else if (r_stretch_cnt != '0) begin
            r_stretch_cnt <= r_stretch_cnt - STRETCH_BITS'(1);
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.SCK          = w_sck;
    assign bus.WS           = w_ws;
    assign bus.o_SAMPLE     = r_sample;
    assign bus.SAMPLE_VALID = r_valid;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: three receivers (left/stretch 8, right/stretch 8,
// left/stretch 511) share one microphone model that follows SCK/WS and drives
// SD with up to one clk of random lag after every SCK fall, filling the unused
// slots with random bits.
module tb_i2s_mic_rx;
    import i2s_pkg::*;

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [23:0] exp_ch0;
        logic [23:0] exp_ch1;
    } vec_t;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_mic_rx_if b0 ();
    i2s_mic_rx_if b1 ();
    i2s_mic_rx_if b2 ();

    i2s_mic_rx #(.CLK_DIV(4), .VALID_STRETCH(8),   .CHANNEL(0)) u_dut0 (.clk(clk), .RESET(RESET), .bus(b0));
    i2s_mic_rx #(.CLK_DIV(4), .VALID_STRETCH(8),   .CHANNEL(1)) u_dut1 (.clk(clk), .RESET(RESET), .bus(b1));
    i2s_mic_rx #(.CLK_DIV(4), .VALID_STRETCH(511), .CHANNEL(0)) u_dut2 (.clk(clk), .RESET(RESET), .bus(b2));

    logic mic_sd = 1'b0;
    assign b0.SD = mic_sd;
    assign b1.SD = mic_sd;
    assign b2.SD = mic_sd;

    logic [2:0] w_vld;
    assign w_vld = {b2.SAMPLE_VALID, b1.SAMPLE_VALID, b0.SAMPLE_VALID};

    // Microphone model state.
    logic [23:0] pend_l = 24'h0, pend_r = 24'h0, cur_l = 24'h0, cur_r = 24'h0;
    int          mic_slot    = 0;
    logic        mic_prev_ws = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Microphone: slot counter restarts on every WS change, new words latch
    // at the start of their channel, the bit for slot s is word[24-s].
    initial begin
        logic [23:0] word;
        logic        nxt;
        int          d;
        forever begin
            @(negedge b0.SCK or posedge RESET);
            if (RESET) begin
                mic_slot    = 0;
                mic_prev_ws = 1'b0;
                cur_l       = pend_l;
                cur_r       = pend_r;
                mic_sd      = 1'b0;
            end else begin
                if (b0.WS != mic_prev_ws) begin
                    mic_slot = 0;
                    if (b0.WS) cur_r = pend_r;
                    else       cur_l = pend_l;
                end else begin
                    mic_slot++;
                end
                mic_prev_ws = b0.WS;
                word = b0.WS ? cur_r : cur_l;
                if (mic_slot >= 1 && mic_slot <= 24) nxt = word[24 - mic_slot];
                else                                  nxt = 1'($urandom_range(0, 1));
                d = $urandom_range(0, 10);
                #d;
                if (!RESET) mic_sd = nxt;
            end
        end
    end

    // Clock monitor: SCK period 8 clk, WS changes only with an SCK fall, every 256 clk.
    int   sck_err = 0, ws_err = 0, sck_rises = 0, ws_edges = 0;
    int   last_rise = -1, last_ws = -1;
    logic p_sck = 1'b0, p_ws = 1'b0;
    initial forever begin
        @(negedge clk);
        if (RESET) begin
            last_rise = -1; last_ws = -1; p_sck = 1'b0; p_ws = 1'b0;
        end else begin
            if (b0.SCK && !p_sck) begin
                if (last_rise >= 0 && cyc - last_rise != 8) sck_err++;
                last_rise = cyc;
                sck_rises++;
            end
            if (b0.WS != p_ws) begin
                ws_edges++;
                if (!(p_sck && !b0.SCK)) ws_err++;
                if (last_ws >= 0 && cyc - last_ws != 256) ws_err++;
                last_ws = cyc;
            end
            p_sck = b0.SCK;
            p_ws  = b0.WS;
        end
    end

    // Valid monitor: dut0 high 8 clk, rises 512 apart; dut2 high 511, low 1.
    int   v0_err = 0, v2_err = 0, n_rise0 = 0, n_rise2 = 0;
    int   r0_last = -1, r2_last = -1, f2_last = -1;
    logic p_v0 = 1'b0, p_v2 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (RESET) begin
            p_v0 = 1'b0; p_v2 = 1'b0; r0_last = -1; r2_last = -1; f2_last = -1;
        end else begin
            if (b0.SAMPLE_VALID && !p_v0) begin
                if (r0_last >= 0 && cyc - r0_last != 512) v0_err++;
                r0_last = cyc;
                n_rise0++;
            end
            if (!b0.SAMPLE_VALID && p_v0 && cyc - r0_last != 8) v0_err++;
            if (b2.SAMPLE_VALID && !p_v2) begin
                if (r2_last >= 0 && cyc - r2_last != 512) v2_err++;
                if (f2_last >= 0 && cyc - f2_last != 1) v2_err++;
                r2_last = cyc;
                n_rise2++;
            end
            if (!b2.SAMPLE_VALID && p_v2) begin
                if (cyc - r2_last != 511) v2_err++;
                f2_last = cyc;
            end
            p_v0 = b0.SAMPLE_VALID;
            p_v2 = b2.SAMPLE_VALID;
        end
    end

    // Wait (bounded) for a SAMPLE_VALID rising edge of receiver idx.
    task automatic wait_rise(input int idx, input int budget, output int at, output bit ok);
        logic prev, cur;
        prev = w_vld[idx];
        ok   = 1'b0;
        at   = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = w_vld[idx];
            if (cur && !prev) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            prev = cur;
        end
        if (!ok) check($sformatf("timeout_valid%0d", idx), 32'd0, 32'd1);
    endtask

    initial begin
        vec_t        vecs[5];
        int          c0, at;
        bit          ok;
        int          base0, base2;
        logic [23:0] exp_l, exp_r;

        vecs[0] = '{24'h800001, 24'h7FFFFF, 24'h800001, 24'h7FFFFF};
        vecs[1] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        vecs[2] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
        vecs[3] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000};
        vecs[4] = '{24'h7FFFFF, 24'h800001, 24'h7FFFFF, 24'h800001};

        pend_l = vecs[0].left;
        pend_r = vecs[0].right;

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_sck",   32'(b0.SCK), 32'd0);
        check("rst_ws",    32'(b0.WS), 32'd0);
        check("rst_sample", 32'(b0.o_SAMPLE), 32'd0);
        check("rst_valid0", 32'(b0.SAMPLE_VALID), 32'd0);
        check("rst_valid2", 32'(b2.SAMPLE_VALID), 32'd0);

        // First SCK rise CLK_DIV cycles after release; first valid after the discarded frame.
        c0 = cyc;
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b0.SCK) break;
        end
        check("sck_first_rise", 32'(cyc - c0), 32'd4);
        wait_rise(0, 1000, at, ok);
        check("first_valid_latency", 32'(at - c0), 32'd709);

        // Table-driven frames: one vector per frame, both channels.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wait_rise(0, 600, at, ok);
            check($sformatf("vec%0d_ch0", i), 32'(b0.o_SAMPLE), 32'(vecs[i].exp_ch0));
            check($sformatf("vec%0d_ch0_s511", i), 32'(b2.o_SAMPLE), 32'(vecs[i].exp_ch0));
            wait_rise(1, 600, at, ok);
            check($sformatf("vec%0d_ch1", i), 32'(b1.o_SAMPLE), 32'(vecs[i].exp_ch1));
            if (i < 4) begin
                pend_l = vecs[i + 1].left;
                pend_r = vecs[i + 1].right;
            end
        end

        // Reset for 3 cycles at slot 12 of a left word.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!b0.WS && mic_slot == 12) break;
        end
        check("reached_left_slot12", 32'(mic_slot), 32'd12);
        repeat (2) @(negedge clk);
        pend_l = vecs[2].left;
        pend_r = vecs[2].right;
        RESET = 1'b1;
        @(negedge clk);
        check("midrst_sample0", 32'(b0.o_SAMPLE), 32'd0);
        check("midrst_valid0",  32'(b0.SAMPLE_VALID), 32'd0);
        check("midrst_sample2", 32'(b2.o_SAMPLE), 32'd0);
        check("midrst_valid2",  32'(b2.SAMPLE_VALID), 32'd0);
        repeat (2) @(negedge clk);
        c0 = cyc;
        RESET = 1'b0;
        wait_rise(0, 1000, at, ok);
        check("midrst_first_valid_latency", 32'(at - c0), 32'd709);
        check("midrst_first_sample", 32'(b0.o_SAMPLE), 32'(vecs[2].exp_ch0));
        wait_rise(1, 600, at, ok);
        check("midrst_first_sample_ch1", 32'(b1.o_SAMPLE), 32'(vecs[2].exp_ch1));

        // Random words with jittered SD, one frame each.
        base0 = n_rise0;
        base2 = n_rise2;
        for (int f = 0; f < 40; f++) begin
            exp_l  = 24'($urandom);
            exp_r  = 24'($urandom);
            pend_l = exp_l;
            pend_r = exp_r;
            wait_rise(0, 600, at, ok);
            check($sformatf("rnd%0d_ch0", f), 32'(b0.o_SAMPLE), 32'(exp_l));
            check($sformatf("rnd%0d_ch0_s511", f), 32'(b2.o_SAMPLE), 32'(exp_l));
            wait_rise(1, 600, at, ok);
            check($sformatf("rnd%0d_ch1", f), 32'(b1.o_SAMPLE), 32'(exp_r));
        end
        check("rises_per_frame_s8",   32'(n_rise0 - base0), 32'd40);
        check("rises_per_frame_s511", 32'(n_rise2 - base2), 32'd40);

        // Monitor results.
        check("sck_period_errors", 32'(sck_err), 32'd0);
        check("ws_timing_errors",  32'(ws_err), 32'd0);
        check("sck_seen",          32'(sck_rises > 1000), 32'd1);
        check("ws_seen",           32'(ws_edges > 50), 32'd1);
        check("valid8_timing_errors",   32'(v0_err), 32'd0);
        check("valid511_timing_errors", 32'(v2_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Run-length guard.
    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
